rx: RTL and testbench
=====================

# rx

Serial-link receiver: the far end of the single-wire flit channel driven by `tx`. It samples `serial_in` every `clk`, detects the start bit and shifts in `SIZE` data bits LSB first. Each assembled flit goes into a small output FIFO for the router input port. The FIFO fill level drives `channel_busy` back to the transmitter, so a new frame is never started when it cannot be stored.

## Interface
- `routerid`, -1: router index; when > -1, each accepted flit is printed with `$display`.
- `port`, "unknown": port label used in `$display`.
- `SIZE`, 8: flit width in bits.
- `DEPTH`, 2: output FIFO depth in flits (≥ 1).

Ports:
- `clk` input 1: sole clock; `serial_in` is sampled on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `serial_in` input 1: link wire from `tx` `serial_out`; idles low.
- `out_data` output SIZE: flit at FIFO head; 0 when empty.
- `out_valid` output 1: FIFO non-empty.
- `out_ack` input 1: pop the head when `out_valid & out_ack`.
- `channel_busy` output 1: high when FIFO count == DEPTH; to `tx` `channel_busy`.
- `rx_active` output 1: high in DATA and GAP states.
- `frame_err` output 1: one-cycle pulse on a gap violation.
- `overflow` output 1: sticky; set when a flit completes while the FIFO is full and not popping that cycle.

## Operation
- Wire frame, one bit per cycle: a `1` start bit, then `d[0]` … `d[SIZE-1]`, then at least one `0` gap cycle. No stop bit is sent. The line is low when idle.
- FSM:
  - IDLE: sample 1 → DATA, with `bitcnt`=0. Sample 0 → stay in IDLE.
  - DATA: shift the sample into `shreg[bitcnt]` and increment `bitcnt`. When `bitcnt`==SIZE-1, push `{sample, shreg[SIZE-2:0]}` to the FIFO → GAP.
  - GAP: sample 0 → IDLE. Sample 1 → pulse `frame_err`, then → IDLE. That 1 is not taken as a start bit.
- Push/pop rules:
  - Push and pop in the same cycle: count is unchanged.
  - Push while full with a same-cycle pop: the flit is accepted.
  - Push while full with no pop: the flit is dropped, `overflow` is set and FIFO contents are unchanged.
- `out_ack` while empty is ignored.
- On a pushed flit with `routerid > -1`: `$display("[%g] router %g: (%s) received : %d", $time, routerid, port, data)`.
- Reset (`reset`==0 at an edge), including mid-frame:
  - state goes to IDLE; `bitcnt`, `shreg` and the FIFO are cleared;
  - `out_data`=0, `out_valid`=0, `channel_busy`=0, `rx_active`=0, `frame_err`=0, `overflow`=0;
  - a partial frame is discarded.

## Timing
- Let S be the cycle in which the start bit is on the wire:
  - data bit k is sampled at the end of cycle S+1+k;
  - the FIFO write happens at the end of cycle S+SIZE;
  - the gap bit is checked at the end of cycle S+SIZE+1;
  - the earliest next start bit is in cycle S+SIZE+2.
- `out_valid` rises in cycle S+SIZE+1 if the FIFO was empty (fall-through, zero added latency).
- `channel_busy` is a registered count compare, valid in cycle S+SIZE+1. That is the cycle in which `tx` samples it for the next frame, so `tx` sees full before it can start again.
- `rx_active` is high from S+1 through S+SIZE+1.
- `frame_err` is high for exactly cycle S+SIZE+2.
- The pop takes effect at the edge. `out_data` and `out_valid` show the next entry in the following cycle.

## Structure
- Shared package: the `SIZE` default and the state encoding (IDLE/DATA/GAP). `tx` uses the same `SIZE`.
- One sub-module, `rx_fifo`:
  - parameters SIZE and DEPTH;
  - ports push, push_data, pop, head, count, full, empty;
  - circular buffer with wrap-around pointers.
- The FSM, shift register and `overflow` logic live in `rx`.

## Test plan
- Single frame, SIZE=8, wire 1 then 0x5A LSB first, then 0 → `out_data`=0x5A, `out_valid` in cycle S+9, `frame_err`=0.
- Back-to-back `tx`→`rx` loopback of flits 0x01, 0x80, 0xFF, 0x00 with `out_ack` held at 0, DEPTH=2:
  - `channel_busy` rises after the second flit;
  - `tx` holds the third flit until `out_ack` pops;
  - all four flits arrive in order, `overflow`=0.
- Forced 1 in the gap cycle after flit 0x33 → 0x33 is stored, `frame_err` pulses once, FSM is in IDLE.
- FIFO full, third frame injected directly on the wire:
  - with `out_ack`=1 in the push cycle → the flit is accepted;
  - repeated without `out_ack` → the flit is dropped and `overflow` stays 1.
- `reset`=0 asserted at data bit 4 → all outputs 0 next cycle; a following clean frame 0xC3 is received correctly.
- `out_ack` pulsed while empty → no change; count is never negative, pointers stay aligned.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the serial flit link: default flit width and the
// receiver state encoding.
package rx_pkg;

  localparam int RX_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Output flit FIFO for the receiver: circular buffer with wrap-around
// pointers and fall-through head. A push while full is only taken when the
// head is popped in the same cycle.
module rx_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [SIZE-1:0] push_data,
  input  logic            pop,
  output logic [SIZE-1:0] head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_push;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = empty ? '0 : r_mem[r_rd_ptr];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  // Pointer, count and storage update; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= wrap_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= wrap_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx.sv
// Serial-link receiver: detects a start bit, shifts in SIZE data bits LSB
// first, checks the gap cycle and queues each flit in the output FIFO whose
// fill level throttles the transmitter via channel_busy.
module rx
  import rx_pkg::*;
#(
  parameter int routerid = -1,
  parameter     port     = "unknown",
  parameter int SIZE     = RX_SIZE,
  parameter int DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ack,
  output logic            channel_busy,
  output logic            rx_active,
  output logic            frame_err,
  output logic            overflow
);

  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rx_state_e       r_state;
  rx_state_e       w_state_nxt;
  logic [BW-1:0]   r_bitcnt;
  logic [SIZE-1:0] r_shreg;
  logic [SIZE-1:0] w_flit;
  logic            w_flit_done;
  logic            w_gap_err;
  logic            r_frame_err;
  logic            r_overflow;
  logic [SIZE-1:0] w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;

  rx_fifo #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_flit_done),
    .push_data (w_flit),
    .pop       (out_ack),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_pop        = out_ack & ~w_empty;
  assign out_data     = w_head;
  assign out_valid    = ~w_empty;
  assign channel_busy = (w_count == CW'(DEPTH));
  assign rx_active    = (r_state == ST_DATA) || (r_state == ST_GAP);
  assign frame_err    = r_frame_err;
  assign overflow     = r_overflow;

  // Last data bit goes straight from the wire into the flit being pushed.
  always_comb begin
    w_flit         = r_shreg;
    w_flit[SIZE-1] = serial_in;
  end

  // Next-state logic: frame sequencing and gap check.
  always_comb begin
    w_state_nxt = r_state;
    w_flit_done = 1'b0;
    w_gap_err   = 1'b0;
    case (r_state)
      ST_IDLE: if (serial_in) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (r_bitcnt == BW'(SIZE - 1)) begin
          w_flit_done = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_gap_err   = serial_in;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Bit counter and shift register; a reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else if (r_state == ST_IDLE && serial_in) begin
      r_bitcnt <= '0;
    end else if (r_state == ST_DATA) begin
      r_shreg[r_bitcnt] <= serial_in;
      r_bitcnt          <= r_bitcnt + BW'(1);
    end
  end

  // Gap-violation pulse and sticky overflow on a flit lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_gap_err;
      if (w_flit_done && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Trace of every flit accepted into the FIFO when a router index is given.
  always @(posedge clk) begin
    if (reset && w_flit_done && (!w_full || w_pop) && routerid > -1)
      $display("[%g] router %g: (%s) received : %d", $time, routerid, port, w_flit);
  end
`endif

endmodule

// File: tb/tb_rx.sv
// Bench for rx: emulates the transmitter on the wire and keeps a queue model
// of the FIFO contents and the sticky overflow flag.
module tb_rx;

  localparam int SIZE  = 8;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            serial_in = 1'b0;
  logic            out_ack = 1'b0;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            channel_busy;
  logic            rx_active;
  logic            frame_err;
  logic            overflow;

  int n_checks = 0;
  int n_errs   = 0;

  logic [SIZE-1:0] mq[$];
  bit              m_ovf = 1'b0;

  always #5 clk = ~clk;

  rx #(
    .routerid (-1),
    .port     ("tb"),
    .SIZE     (SIZE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ack      (out_ack),
    .channel_busy (channel_busy),
    .rx_active    (rx_active),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  function automatic logic [SIZE-1:0] m_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic bit m_full();
    return mq.size() == DEPTH;
  endfunction

  function automatic logic ack_for(input int mode, input bit last);
    case (mode)
      1:       return ($urandom_range(0, 1) != 0);
      2:       return last;
      default: return 1'b0;
    endcase
  endfunction

  // One wire cycle; 'last' marks the cycle carrying the final data bit.
  task automatic cyc(input logic sin, input logic ack, input bit last,
                     input logic [SIZE-1:0] flit);
    bit pop;
    bit accept;
    serial_in = sin;
    out_ack   = ack;
    pop       = ack && (mq.size() != 0);
    accept    = last && ((mq.size() < DEPTH) || pop);
    if (last && !accept) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (accept) mq.push_back(flit);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [SIZE-1:0] d, input logic gapbit, input int mode);
    cyc(1'b1, ack_for(mode, 1'b0), 1'b0, '0);
    for (int k = 0; k < SIZE; k++)
      cyc(d[k], ack_for(mode, k == SIZE - 1), k == SIZE - 1, d);
    cyc(gapbit, ack_for(mode, 1'b0), 1'b0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() != 0; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0; serial_in = 1'b0; out_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; serial_in = 1'b1; out_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, channel_busy, rx_active, frame_err, overflow, out_data} !== '0) begin
      n_errs++;
      $display("FAIL reset_outputs got v%b b%b a%b e%b o%b d%h exp all 0",
               out_valid, channel_busy, rx_active, frame_err, overflow, out_data);
    end
    reset = 1'b1; serial_in = 1'b0; out_ack = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [SIZE-1:0] d;
    d = 8'h5A;
    cyc(1'b1, 1'b0, 1'b0, '0);
    n_checks++;
    if (rx_active !== 1'b1) begin
      n_errs++; $display("FAIL single_active got %b exp 1", rx_active);
    end
    for (int k = 0; k < SIZE - 1; k++) cyc(d[k], 1'b0, 1'b0, d);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errs++; $display("FAIL single_early_valid got %b exp 0", out_valid);
    end
    cyc(d[SIZE-1], 1'b0, 1'b1, d);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      n_errs++; $display("FAIL single_data got v%b %h exp v1 5a", out_valid, out_data);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (frame_err !== 1'b0 || rx_active !== 1'b0) begin
      n_errs++; $display("FAIL single_end got err%b act%b exp 0 0", frame_err, rx_active);
    end
    cyc(1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errs++; $display("FAIL single_pop got v%b %h exp v0 00", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [SIZE-1:0] f [4];
    int nx;
    f[0] = 8'h01; f[1] = 8'h80; f[2] = 8'hFF; f[3] = 8'h00;
    nx = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_full()) begin
        for (int w = 0; w < 3; w++) cyc(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (channel_busy !== 1'b1) begin
          n_errs++; $display("FAIL b2b_hold_busy got %b exp 1", channel_busy);
        end
        n_checks++;
        if (out_data !== f[nx]) begin
          n_errs++; $display("FAIL b2b_order got %h exp %h", out_data, f[nx]);
        end
        nx++;
        cyc(1'b0, 1'b1, 1'b0, '0);
      end
      send(f[i], 1'b0, 0);
      if (i == 1) begin
        n_checks++;
        if (channel_busy !== 1'b1) begin
          n_errs++; $display("FAIL b2b_busy_after_two got %b exp 1", channel_busy);
        end
      end
    end
    while (nx < 4) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== f[nx]) begin
        n_errs++; $display("FAIL b2b_drain got v%b %h exp v1 %h", out_valid, out_data, f[nx]);
      end
      nx++;
      cyc(1'b0, 1'b1, 1'b0, '0);
    end
    n_checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      n_errs++; $display("FAIL b2b_final got ovf%b v%b exp 0 0", overflow, out_valid);
    end
  endtask

  task automatic test_gap_err();
    logic [SIZE-1:0] d;
    d = 8'h33;
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < SIZE; k++) cyc(d[k], 1'b0, k == SIZE - 1, d);
    n_checks++;
    if (frame_err !== 1'b0 || rx_active !== 1'b1) begin
      n_errs++; $display("FAIL gap_in_gap got err%b act%b exp 0 1", frame_err, rx_active);
    end
    cyc(1'b1, 1'b0, 1'b0, '0);
    n_checks++;
    if (frame_err !== 1'b1 || rx_active !== 1'b0 || out_data !== 8'h33) begin
      n_errs++;
      $display("FAIL gap_pulse got err%b act%b %h exp 1 0 33", frame_err, rx_active, out_data);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (frame_err !== 1'b0 || rx_active !== 1'b0) begin
      n_errs++; $display("FAIL gap_after got err%b act%b exp 0 0", frame_err, rx_active);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [SIZE-1:0] a, b, c, d;
    a = SIZE'($urandom); b = SIZE'($urandom); c = SIZE'($urandom); d = SIZE'($urandom);
    send(a, 1'b0, 0);
    send(b, 1'b0, 0);
    send(c, 1'b0, 2);
    n_checks++;
    if (channel_busy !== 1'b1 || overflow !== 1'b0 || out_data !== b) begin
      n_errs++;
      $display("FAIL ovf_accept got b%b o%b %h exp 1 0 %h", channel_busy, overflow, out_data, b);
    end
    send(d, 1'b0, 0);
    n_checks++;
    if (overflow !== 1'b1 || out_data !== b) begin
      n_errs++; $display("FAIL ovf_drop got o%b %h exp 1 %h", overflow, out_data, b);
    end
    cyc(1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (out_data !== c || channel_busy !== 1'b0) begin
      n_errs++; $display("FAIL ovf_next got %h b%b exp %h 0", out_data, channel_busy, c);
    end
    drain();
    n_checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b0) begin
      n_errs++; $display("FAIL ovf_sticky got o%b v%b exp 1 0", overflow, out_valid);
    end
  endtask

  task automatic test_midreset();
    logic [SIZE-1:0] d;
    d = SIZE'($urandom);
    send(SIZE'($urandom), 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) cyc(d[k], 1'b0, 1'b0, d);
    reset = 1'b0; serial_in = d[4];
    @(posedge clk); #1;
    reset = 1'b1;
    mq.delete(); m_ovf = 1'b0;
    n_checks++;
    if ({out_valid, channel_busy, rx_active, frame_err, overflow, out_data} !== '0) begin
      n_errs++;
      $display("FAIL midreset_outputs got v%b b%b a%b e%b o%b d%h exp all 0",
               out_valid, channel_busy, rx_active, frame_err, overflow, out_data);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    send(8'hC3, 1'b0, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC3 || frame_err !== 1'b0) begin
      n_errs++; $display("FAIL midreset_clean got v%b %h e%b exp 1 c3 0", out_valid, out_data, frame_err);
    end
    drain();
  endtask

  task automatic test_empty_ack();
    logic [SIZE-1:0] x, y;
    x = SIZE'($urandom); y = SIZE'($urandom);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || channel_busy !== 1'b0) begin
        n_errs++; $display("FAIL empty_ack got v%b %h b%b exp 0 00 0", out_valid, out_data, channel_busy);
      end
    end
    send(x, 1'b0, 0);
    send(y, 1'b0, 0);
    n_checks++;
    if (channel_busy !== 1'b1 || out_data !== x) begin
      n_errs++; $display("FAIL empty_refill got b%b %h exp 1 %h", channel_busy, out_data, x);
    end
    cyc(1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== y) begin
      n_errs++; $display("FAIL empty_second got v%b %h exp 1 %h", out_valid, out_data, y);
    end
    cyc(1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (out_valid !== 1'b0 || channel_busy !== 1'b0) begin
      n_errs++; $display("FAIL empty_final got v%b b%b exp 0 0", out_valid, channel_busy);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      for (int w = 0; w < 50 && m_full(); w++)
        cyc(1'b0, ($urandom_range(0, 1) != 0), 1'b0, '0);
      for (int g = $urandom_range(0, 2); g > 0; g--)
        cyc(1'b0, ($urandom_range(0, 1) != 0), 1'b0, '0);
      send(SIZE'($urandom), 1'b0, 1);
      n_checks++;
      if (out_valid !== (mq.size() != 0) || out_data !== m_head() ||
          channel_busy !== m_full() || overflow !== m_ovf) begin
        n_errs++;
        $display("FAIL random_%0d got v%b %h b%b o%b exp v%b %h b%b o%b", f,
                 out_valid, out_data, channel_busy, overflow,
                 (mq.size() != 0), m_head(), m_full(), m_ovf);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap_err();
    test_overflow();
    test_midreset();
    test_empty_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
